// File: rtl/cirno9_sram_arb.sv
// cirno9_sram_arb: two-master arbiter in front of the shared single-port sram32.
// Master 0 is the cirno9_core load/store/fetch port and master 1 is the DMA/debug
// port. One access is granted per cycle with zero arbitration latency. Read data
// returns the following cycle and is routed to the master that issued the read.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   i_m0_req/wen/adr/wdat             master 0 request (wen==0 means read)
//   o_m0_rdy, o_m0_rvld, o_m0_rdat    master 0 accept, read valid, read data
//   i_m1_* / o_m1_*                   master 1 equivalents
//   o_sram_en/wen/adr/din             sram32 command
//   i_sram_dout                       sram32 read data, valid the cycle after a read
//
// Build option:
//   CIRNO9_SRAM_ARB_RR_EN  defined: pure round-robin priority (STARVE_MAX removed).
//                          undefined: m0-favoured priority, m1 forced after
//                          STARVE_MAX consecutive m0 grants while m1 waits.

module cirno9_sram_arb #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
`ifndef CIRNO9_SRAM_ARB_RR_EN
  ,
  parameter int unsigned STARVE_MAX = 4
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_m0_req,
  input  logic [3:0]    i_m0_wen,
  input  logic [AW-1:0] i_m0_adr,
  input  logic [DW-1:0] i_m0_wdat,
  output logic          o_m0_rdy,
  output logic          o_m0_rvld,
  output logic [DW-1:0] o_m0_rdat,
  input  logic          i_m1_req,
  input  logic [3:0]    i_m1_wen,
  input  logic [AW-1:0] i_m1_adr,
  input  logic [DW-1:0] i_m1_wdat,
  output logic          o_m1_rdy,
  output logic          o_m1_rvld,
  output logic [DW-1:0] o_m1_rdat,
  output logic          o_sram_en,
  output logic [3:0]    o_sram_wen,
  output logic [AW-1:0] o_sram_adr,
  output logic [DW-1:0] o_sram_din,
  input  logic [DW-1:0] i_sram_dout
);

  typedef enum logic {
    PRI_M0 = 1'b0,
    PRI_M1 = 1'b1
  } pri_e;

  pri_e pri_q;
  logic gnt_m0_c;
  logic gnt_m1_c;
  logic tag_vld_q;
  logic tag_own_q;

  // Winner selection; gated by rst_n so nothing is granted while in reset.
  always_comb begin
    gnt_m0_c = 1'b0;
    gnt_m1_c = 1'b0;
    if (rst_n) begin
      if (i_m0_req && (!i_m1_req || (pri_q == PRI_M0))) begin
        gnt_m0_c = 1'b1;
      end else if (i_m1_req) begin
        gnt_m1_c = 1'b1;
      end
    end
  end

  assign o_m0_rdy = gnt_m0_c;
  assign o_m1_rdy = gnt_m1_c;

  // Same-cycle issue of the granted master's command; idle bus is all zero.
  always_comb begin
    o_sram_en  = gnt_m0_c | gnt_m1_c;
    o_sram_wen = 4'b0000;
    o_sram_adr = '0;
    o_sram_din = '0;
    if (gnt_m0_c) begin
      o_sram_wen = i_m0_wen;
      o_sram_adr = i_m0_adr;
      o_sram_din = i_m0_wdat;
    end else if (gnt_m1_c) begin
      o_sram_wen = i_m1_wen;
      o_sram_adr = i_m1_adr;
      o_sram_din = i_m1_wdat;
    end
  end

  // Read-return tag: remembers that last cycle's access was a read and whose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= 1'b0;
      tag_own_q <= 1'b0;
    end else begin
      tag_vld_q <= (gnt_m0_c && (i_m0_wen == 4'b0000)) ||
                   (gnt_m1_c && (i_m1_wen == 4'b0000));
      tag_own_q <= gnt_m1_c;
    end
  end

  // Route sram data to the owner only; the other master sees zero.
  assign o_m0_rvld = tag_vld_q & ~tag_own_q;
  assign o_m1_rvld = tag_vld_q &  tag_own_q;
  assign o_m0_rdat = o_m0_rvld ? i_sram_dout : '0;
  assign o_m1_rdat = o_m1_rvld ? i_sram_dout : '0;

`ifdef CIRNO9_SRAM_ARB_RR_EN
  // Round-robin: after any grant the other master is favoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q <= PRI_M0;
    end else if (gnt_m0_c) begin
      pri_q <= PRI_M1;
    end else if (gnt_m1_c) begin
      pri_q <= PRI_M0;
    end
  end
`else
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt_q;
  logic          starve_inc_c;

  assign starve_inc_c = gnt_m0_c & i_m1_req;

  // m0-favoured priority; m1 forced after STARVE_MAX back-to-back losses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q        <= PRI_M0;
      starve_cnt_q <= '0;
    end else begin
      if (gnt_m1_c || !i_m1_req) begin
        starve_cnt_q <= '0;
      end else if (starve_inc_c) begin
        starve_cnt_q <= starve_cnt_q + CW'(1);
      end
      if (pri_q == PRI_M0) begin
        if (starve_inc_c && (starve_cnt_q == CW'(STARVE_MAX - 1))) begin
          pri_q <= PRI_M1;
        end
      end else begin
        if (gnt_m1_c) begin
          pri_q <= PRI_M0;
        end
      end
    end
  end
`endif

endmodule
